// File: rtl/mult_seq_controller.sv
// mult_seq_controller
//   Control FSM for the sequential signed shift-add multiplier. It issues one
//   load cycle and then WIDTH step cycles. The final step is flagged so the
//   datapath subtracts the MSB partial product. The block also tracks the
//   display window offset that scrolls across the product's decimal digits.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start_p   in   one-cycle pulse, begin multiplication
//   left_p    in   one-cycle pulse, scroll toward more significant digits
//   right_p   in   one-cycle pulse, scroll toward less significant digits
//   load      out  datapath loads operands / clears accumulator (one cycle)
//   step      out  datapath performs one add/shift iteration
//   last_step out  qualifies step: final iteration, subtract instead of add
//   busy      out  high in LOAD and RUN
//   done      out  level, high while the product is valid
//   win_pos   out  display window offset, 0 = least significant WIN digits
//   step_cnt  out  current iteration index (debug LEDs)
module mult_seq_controller #(
    parameter int WIDTH   = 8,
    parameter int NDIGITS = 5,
    parameter int WIN     = 4,
    parameter int CNT_W   = 4,
    parameter int POS_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic             left_p,
    input  logic             right_p,
    output logic             load,
    output logic             step,
    output logic             last_step,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] win_pos,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] MAX_POS  = POS_W'(NDIGITS - WIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A start pulse takes priority over any scroll in the same cycle.
                if (start_p) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    pos_d   = '0;
                end else if (left_p && !right_p && (pos_q != MAX_POS)) begin
                    pos_d = pos_q + 1'b1;
                end else if (right_p && !left_p && (pos_q != '0)) begin
                    pos_d = pos_q - 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                // The counter holds at the last index, so DONE shows WIDTH-1.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded only from registered state and counter.
    assign load      = (state_q == LOAD);
    assign step      = (state_q == RUN);
    assign last_step = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign done      = (state_q == DONE);
    assign win_pos   = pos_q;
    assign step_cnt  = cnt_q;

endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
- Control FSM for the sequential signed multiplier on the board.
- Inputs are the single-cycle pulses produced by the push-button detector chain: start, scroll-left, scroll-right.
- Sequences the shift-add datapath: load, WIDTH step cycles, and a last-step flag for the signed (MSB-subtract) correction.
- Also owns the display window position used to scroll across the product's decimal digits.

Parameters:
- WIDTH, 8, operand width; number of step cycles per multiplication.
- NDIGITS, 5, number of product magnitude digits available to the display.
- WIN, 4, number of digits visible at once. MAX_POS = NDIGITS-WIN.
- CNT_W, 4, step-counter width; must satisfy 2^CNT_W > WIDTH-1.
- POS_W, 1, window-position width; must satisfy 2^POS_W > MAX_POS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_p  in  1  one-cycle pulse: begin multiplication.
- left_p  in  1  one-cycle pulse: scroll window toward more significant digits.
- right_p  in  1  one-cycle pulse: scroll window toward less significant digits.
- load  out  1  datapath loads operands and clears accumulator; high for exactly one cycle.
- step  out  1  datapath performs one add/shift iteration.
- last_step  out  1  qualifies step: final iteration, datapath subtracts instead of adds (signed MSB weight).
- busy  out  1  high in LOAD and RUN.
- done  out  1  high (level) while product is valid (DONE state).
- win_pos  out  POS_W  display window offset; 0 = least significant WIN digits.
- step_cnt  out  CNT_W  current iteration index, for debug LEDs.

Behaviour:
- Reset: state=IDLE; load, step, last_step, busy, done all 0; win_pos=0; step_cnt=0. Reset takes effect immediately, including mid-RUN; no partial completion is signalled.
- All outputs are registered, Moore-decoded from state and counter; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: start_p -> LOAD.
  - LOAD (1 cycle): load=1, busy=1, step_cnt<=0; unconditionally -> RUN.
  - RUN: step=1, busy=1, step_cnt increments each cycle. last_step=1 when step_cnt==WIDTH-1; that cycle -> DONE.
  - DONE: done=1 until the next start_p, then -> LOAD.
- Latency: start_p sampled high at edge n gives load during cycle n+1, step during cycles n+2..n+1+WIDTH, last_step in cycle n+1+WIDTH, done from cycle n+2+WIDTH.
- start_p during LOAD or RUN is ignored and not queued.
- start_p in DONE restarts: done drops in the LOAD cycle, win_pos resets to 0.
- Scroll: accepted only in IDLE and DONE; ignored while busy.
  - left_p alone: win_pos+1, saturating at MAX_POS.
  - right_p alone: win_pos-1, saturating at 0.
  - left_p and right_p in the same cycle: no change.
  - If MAX_POS=0, win_pos stays 0.
- start_p coinciding with a scroll pulse in DONE: start wins, win_pos<=0.
- Counter never wraps: step_cnt holds WIDTH-1 in DONE and returns to 0 only via LOAD.

Test Plan:
- Reset and basic run (WIDTH=8): pulse start_p at cycle 0 -> load=1 in cycle 1; step=1 in cycles 2..9; last_step=1 only in cycle 9; done=1 from cycle 10; busy=1 in cycles 1..9.
- Ignored start: pulse start_p again at cycle 5 -> no change to the sequence; done still rises at cycle 10 and exactly 8 step cycles occur.
- Scroll saturation (NDIGITS=5, WIN=4): in DONE, left_p x3 -> win_pos 0->1->1->1; right_p x2 -> 1->0->0; left_p+right_p together -> unchanged.
- Scroll blocked while busy: left_p during RUN -> win_pos stays 0. Restart from DONE with win_pos=1 -> win_pos=0 in the LOAD cycle, done=0.
- Async reset mid-RUN: assert rst at cycle 6 between clock edges -> all outputs 0 immediately; after release, IDLE with no done until the next start_p.
- Simultaneous start_p and left_p in DONE -> LOAD entered, win_pos=0, no scroll applied.
